// File: rtl/dct_quant_zigzag.sv
// Quantizes an 8x8 DCT block by reciprocal multiplication and streams it out in zig-zag order.
// Optional macro DCT_QUANT_TBL_LOAD_EN turns the reciprocal ROM into a writable register file.
module dct_quant_zigzag #(
   parameter int IN_W  = 32,
   parameter int FRAC  = 15,
   parameter int OUT_W = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef DCT_QUANT_TBL_LOAD_EN
   input  logic                    tbl_we,
   input  logic [5:0]              tbl_addr,
   input  logic [15:0]             tbl_data,
`endif
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [64*IN_W-1:0]      in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic [5:0]              out_idx,
   output logic                    out_last
);

   localparam int PW = IN_W + 17;
   localparam int SH = FRAC + 16;
   localparam logic signed [PW-1:0] RND  = PW'(1) <<< (SH - 1);
   localparam logic signed [PW-1:0] MAXV = PW'((1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [PW-1:0] MINV = ~MAXV;

   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   // round(65536/Q) for the JPEG luminance table, raster order
   localparam logic [15:0] RECIP [64] = '{
      16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
      16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
      16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
      16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
      16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
      16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
      16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
      16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
   };

   function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
      return (p + RND) >>> SH;
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] s;
      s = v;
      if (v > MAXV) s = MAXV;
      else if (v < MINV) s = MINV;
      return OUT_W'(s);
   endfunction

   function automatic logic signed [OUT_W-1:0] quant(input logic signed [IN_W-1:0] c,
                                                     input logic [15:0] m);
      logic signed [PW-1:0] p;
      p = PW'(c) * PW'($signed({1'b0, m}));
      return saturate(round_shift(p));
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [5:0]              k_q, k_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic [5:0]              out_idx_q, out_idx_d;
   logic                    out_last_q, out_last_d;
   logic                    cap;
   logic signed [IN_W-1:0]  blk_q [64];
   logic [5:0]              r;
   logic [15:0]             m;

   assign r = ZZ[k_q];

`ifdef DCT_QUANT_TBL_LOAD_EN
   logic [15:0] recip_q [64];

   // Table writes land only while idle; a write on the handshake edge is seen by that block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) recip_q[i] <= RECIP[i];
      end else if (tbl_we && state_q == IDLE) begin
         recip_q[tbl_addr] <= tbl_data;
      end
   end

   assign m = recip_q[r];
`else
   assign m = RECIP[r];
`endif

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      in_ready    = 1'b0;
      cap         = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cap     = 1'b1;
               k_d     = 6'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!out_valid_q || out_ready) begin
               out_valid_d = 1'b1;
               out_data_d  = quant(blk_q[r], m);
               out_idx_d   = k_q;
               out_last_d  = (k_q == 6'd63);
               k_d         = k_q + 6'd1;
               if (k_q == 6'd63) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= 6'd0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   // Block buffer: data only, captured on the input handshake
   always_ff @(posedge clk) begin
      if (cap) begin
         for (int i = 0; i < 64; i++) blk_q[i] <= in_data[i*IN_W +: IN_W];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: fixed vectors, rounding/saturation corners, backpressure, reset abort.
module tb_dct_quant_zigzag;
   localparam int IN_W  = 32;
   localparam int FRAC  = 15;
   localparam int OUT_W = 12;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [64*IN_W-1:0]      in_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic signed [OUT_W-1:0] out_data;
   logic [5:0]              out_idx;
   logic                    out_last;
`ifdef DCT_QUANT_TBL_LOAD_EN
   logic                    tbl_we = 1'b0;
   logic [5:0]              tbl_addr = 6'd0;
   logic [15:0]             tbl_data = 16'd0;
`endif

   always #5 clk = ~clk;

   dct_quant_zigzag #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef DCT_QUANT_TBL_LOAD_EN
      .tbl_we    (tbl_we),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int qtab [64] = '{
      16, 11, 10, 16, 24, 40, 51, 61,
      12, 12, 14, 19, 26, 58, 60, 55,
      14, 13, 16, 24, 40, 57, 69, 56,
      14, 17, 22, 29, 51, 87, 80, 62,
      18, 22, 37, 56, 68, 109, 103, 77,
      24, 35, 55, 64, 81, 104, 113, 92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103, 99
   };
   int zz [64];
   int recip_m [64];
   logic signed [31:0] blk [64];
   int exp_q [64];
   int got [64];
   int hs_a, hs_b;

   function automatic int qmodel(input logic signed [31:0] c, input int m);
      longint p, v;
      p = longint'(c) * longint'(m);
      v = (p + (longint'(1) <<< (FRAC + 15))) >>> (FRAC + 16);
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      return int'(v);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_blk();
      for (int i = 0; i < 64; i++) blk[i] = '0;
   endtask

   // mode 0: out_ready held high; mode 1: random out_ready. abort_at >= 0 resets when that k is shown.
   task automatic run_block(input int mode, input int abort_at, output int hs_edge);
      int budget;
      int cnt;
      bit stalled;
      bit rdy;
      logic signed [OUT_W-1:0] h_data;
      logic [5:0] h_idx;
      logic h_last;
      hs_edge = 0;
      budget = 0;
      while (in_ready !== 1'b1 && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("in_ready_wait", in_ready, 1);
      for (int i = 0; i < 64; i++) begin
         in_data[i*IN_W +: IN_W] = blk[i];
         exp_q[i] = qmodel(blk[zz[i]], recip_m[zz[i]]);
         got[i] = 9999;
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      hs_edge = cyc;
      in_valid = 1'b0;
      for (int i = 0; i < 64; i++) in_data[i*IN_W +: IN_W] = $urandom;
`ifdef DCT_QUANT_TBL_LOAD_EN
      tbl_data = 16'd1;
`endif
      chk("entry_out_valid", out_valid, 0);
      chk("entry_in_ready", in_ready, 0);
      cnt = 0;
      stalled = 0;
      budget = 0;
      h_data = '0;
      h_idx = '0;
      h_last = 1'b0;
      while (cnt < 64 && budget < 2000) begin
         @(posedge clk); #1;
         budget++;
         if (cyc == hs_edge + 1) chk("first_valid_latency", out_valid, 1);
         if (out_valid) begin
            if (abort_at >= 0 && int'(out_idx) == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk("abort_out_valid", out_valid, 0);
               chk("abort_in_ready", in_ready, 1);
               chk("abort_out_idx", out_idx, 0);
               out_ready = 1'b0;
               return;
            end
            chk("busy_in_ready", in_ready, 0);
            if (stalled) begin
               chk("hold_data", out_data, h_data);
               chk("hold_idx", out_idx, h_idx);
               chk("hold_last", out_last, h_last);
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (rdy) begin
               chk("data", out_data, exp_q[cnt]);
               chk("idx", out_idx, cnt);
               chk("last", out_last, (cnt == 63) ? 1 : 0);
               if (cnt == 63 && mode == 0) chk("last_edge", cyc - hs_edge, 64);
               got[cnt] = int'(out_data);
               cnt++;
               stalled = 0;
            end else begin
               stalled = 1;
               h_data = out_data;
               h_idx = out_idx;
               h_last = out_last;
            end
         end else begin
            chk("run_in_ready", in_ready, 0);
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            stalled = 0;
         end
      end
      chk("block_complete", cnt, 64);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("done_out_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
   endtask

   initial begin
      int kk;
      int lo, hi;
      kk = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 8) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[kk] = r * 8 + (s - r); kk++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[kk] = r * 8 + (s - r); kk++; end
         end
      end
      for (int i = 0; i < 64; i++) recip_m[i] = (131072 + qtab[i]) / (2 * qtab[i]);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // DC-only block, then AC block back to back for the period check
      clear_blk();
      blk[0] = 32'h0100_0000;
      run_block(0, -1, hs_a);
      chk("dc_k0", got[0], 32);
      chk("dc_k1", got[1], 0);
      chk("dc_k63", got[63], 0);

      clear_blk();
      blk[1] = 32'h0037_0000;
      blk[8] = 32'hFFE2_0000;
      run_block(0, -1, hs_b);
      chk("block_period", hs_b - hs_a, 66);
      chk("ac_k0", got[0], 0);
      chk("ac_k1", got[1], 10);
      chk("ac_k2", got[2], -5);
      chk("ac_k3", got[3], 0);

      // Rounding
      clear_blk();
      blk[0] = 32'h0004_0000;
      run_block(0, -1, hs_a);
      chk("round_p8", got[0], 1);
      blk[0] = 32'hFFFC_0000;
      run_block(0, -1, hs_a);
      chk("round_m8", got[0], 0);
      blk[0] = 32'h000C_0000;
      run_block(0, -1, hs_a);
      chk("round_p24", got[0], 2);

      // Saturation
      blk[0] = 32'h3FFF_8000;
      run_block(0, -1, hs_a);
      chk("sat_pos", got[0], 2047);
      blk[0] = 32'hC000_0000;
      run_block(0, -1, hs_a);
      chk("sat_neg", got[0], -2048);

      // Backpressure with random blocks
      for (int b = 0; b < 10; b++) begin
         for (int i = 0; i < 64; i++) blk[i] = $signed($urandom) >>> $urandom_range(0, 16);
         run_block(1, -1, hs_a);
      end

      // Reset in the middle of a block
      for (int i = 0; i < 64; i++) blk[i] = $signed($urandom) >>> 8;
      run_block(0, 30, hs_a);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_blk();
      blk[0] = 32'h0100_0000;
      run_block(0, -1, hs_a);
      chk("after_abort_k0", got[0], 32);

`ifdef DCT_QUANT_TBL_LOAD_EN
      // Table write on the handshake edge; writes during RUN must be ignored
      tbl_we = 1'b1;
      tbl_addr = 6'd0;
      tbl_data = 16'd8192;
      recip_m[0] = 8192;
      run_block(0, -1, hs_a);
      chk("tbl_write_k0", got[0], 64);
      tbl_we = 1'b0;
      run_block(0, -1, hs_a);
      chk("tbl_run_write_ignored", got[0], 64);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
